uart_tx_scheduler: RTL and testbench

//  Sequences a multi-byte message through the single-byte UART transmitter, one byte per frame, LSB byte first.

---
 rtl/uart_sched_pkg.sv | 20 ++
 rtl/sched_cycle_timer.sv | 28 ++
 rtl/uart_tx_scheduler.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared constants for the UART transmit scheduler: state encoding, default
// timing constants and the counter-width helper.
package uart_sched_pkg;

    localparam int BYTE_W          = 8;
    localparam int DEF_GAP_CYCLES  = 16;
    localparam int DEF_ACK_TIMEOUT = 64;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK = 3'd2;
    localparam logic [2:0] ST_WAIT_TX  = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;

    // One spare bit so a counter sized for the larger limit can never wrap.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/sched_cycle_timer.sv
// Cycle timer: cleared while idle, counts while enabled, flags the last cycle
// of a LIMIT-cycle interval. Saturates at the terminal count.
module sched_cycle_timer #(
    parameter int WIDTH = 8,
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_term
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != TERM)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_term = i_en && (r_count == TERM);

endmodule

// File: rtl/uart_tx_scheduler.sv
// Sends a MSG_LEN-byte message through a single-byte UART transmitter, LSB byte
// first, with Tx_WR/Tx_BUSY handshake, inter-frame gap and accept timeout.
// Optional macro UART_SCHED_REPEAT_EN: resend continuously until `stop`.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int MSG_LEN     = 4,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [BYTE_W*MSG_LEN-1:0]   msg_data,
    input  logic                        Tx_BUSY,
`ifdef UART_SCHED_REPEAT_EN
    input  logic                        stop,
`endif
    output logic                        Tx_EN,
    output logic                        Tx_WR,
    output logic [BYTE_W-1:0]           Tx_DATA,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic [2:0]                  byte_idx
);

    localparam int         CNT_W    = cnt_width(GAP_CYCLES, ACK_TIMEOUT);
    localparam logic [2:0] LAST_IDX = 3'(MSG_LEN - 1);

    logic [2:0]                r_state, r_state_next;
    logic [BYTE_W*MSG_LEN-1:0] r_msg, r_msg_next;
    logic [2:0]                r_idx, r_idx_next;
    logic                      r_tx_wr, r_tx_wr_next;
    logic [BYTE_W-1:0]         r_tx_data, r_tx_data_next;
    logic                      r_busy, r_busy_next;
    logic                      r_done, r_done_next;
    logic                      r_err, r_err_next;

    logic                      w_gap_term;
    logic                      w_ack_term;
    logic                      w_finish;
    logic [BYTE_W-1:0]         w_cur_byte;
    logic [BYTE_W-1:0]         w_msg_bytes [8];

    // Fixed 8-entry byte view so the 3-bit index never selects outside the array.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bytes
            if (gi < MSG_LEN) begin : g_used
                assign w_msg_bytes[gi] = r_msg[gi*BYTE_W +: BYTE_W];
            end else begin : g_unused
                assign w_msg_bytes[gi] = '0;
            end
        end
    endgenerate

    assign w_cur_byte = w_msg_bytes[r_idx];

`ifdef UART_SCHED_REPEAT_EN
    logic r_stop_req;

    // A stop request is remembered until the byte in flight has finished its gap.
    always_ff @(posedge clk) begin
        if (reset || (r_state == ST_IDLE)) begin
            r_stop_req <= 1'b0;
        end else if (stop) begin
            r_stop_req <= 1'b1;
        end
    end

    assign w_finish = r_stop_req || stop;
`else
    assign w_finish = (r_idx == LAST_IDX);
`endif

    sched_cycle_timer #(.WIDTH(CNT_W), .LIMIT(GAP_CYCLES)) u_gap_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clear (r_state != ST_GAP),
        .i_en    (r_state == ST_GAP),
        .o_term  (w_gap_term)
    );

    sched_cycle_timer #(.WIDTH(CNT_W), .LIMIT(ACK_TIMEOUT)) u_ack_timer (
        .clk     (clk),
        .reset   (reset),
        .i_clear (r_state != ST_WAIT_ACK),
        .i_en    (r_state == ST_WAIT_ACK),
        .o_term  (w_ack_term)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_msg     <= '0;
            r_idx     <= '0;
            r_tx_wr   <= 1'b0;
            r_tx_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= r_state_next;
            r_msg     <= r_msg_next;
            r_idx     <= r_idx_next;
            r_tx_wr   <= r_tx_wr_next;
            r_tx_data <= r_tx_data_next;
            r_busy    <= r_busy_next;
            r_done    <= r_done_next;
            r_err     <= r_err_next;
        end
    end

    always_comb begin
        r_state_next = r_state;
        case (r_state)
            ST_IDLE:     if (start) r_state_next = ST_LOAD;
            ST_LOAD:     if (!Tx_BUSY) r_state_next = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (Tx_BUSY) begin
                    r_state_next = ST_WAIT_TX;
                end else if (w_ack_term) begin
                    r_state_next = ST_IDLE;
                end
            end
            ST_WAIT_TX:  if (!Tx_BUSY) r_state_next = ST_GAP;
            ST_GAP:      if (w_gap_term) r_state_next = w_finish ? ST_IDLE : ST_LOAD;
            default:     r_state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered; this process computes their next values.
    always_comb begin
        r_msg_next     = r_msg;
        r_idx_next     = r_idx;
        r_tx_wr_next   = 1'b0;
        r_tx_data_next = r_tx_data;
        r_done_next    = 1'b0;
        r_err_next     = 1'b0;
        r_busy_next    = (r_state_next != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    r_msg_next = msg_data;
                    r_idx_next = '0;
                end
            end
            ST_LOAD: begin
                if (!Tx_BUSY) begin
                    r_tx_wr_next   = 1'b1;
                    r_tx_data_next = w_cur_byte;
                end
            end
            ST_WAIT_ACK: begin
                if (!Tx_BUSY && w_ack_term) r_err_next = 1'b1;
            end
            ST_GAP: begin
                if (w_gap_term) begin
                    if (w_finish) begin
                        r_done_next = 1'b1;
                    end else begin
                        r_idx_next = (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign Tx_EN    = r_busy;
    assign busy     = r_busy;
    assign Tx_WR    = r_tx_wr;
    assign Tx_DATA  = r_tx_data;
    assign done     = r_done;
    assign err      = r_err;
    assign byte_idx = r_idx;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler (default single-shot build): a
// behavioural transmitter model plus event log, checked with immediate asserts.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

    localparam int MSG_LEN = 4;
    localparam int GAP     = 16;
    localparam int ACK     = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] msg_data;
    logic        Tx_BUSY;
`ifdef UART_SCHED_REPEAT_EN
    logic        stop;
`endif
    logic        Tx_EN;
    logic        Tx_WR;
    logic [7:0]  Tx_DATA;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  byte_idx;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.MSG_LEN(MSG_LEN), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .msg_data (msg_data),
        .Tx_BUSY  (Tx_BUSY),
`ifdef UART_SCHED_REPEAT_EN
        .stop     (stop),
`endif
        .Tx_EN    (Tx_EN),
        .Tx_WR    (Tx_WR),
        .Tx_DATA  (Tx_DATA),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .byte_idx (byte_idx)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model knobs and event log
    int         busy_len  = 10;
    bit         ack_en    = 1'b1;
    int         hold_until = 0;
    int         remain    = 0;
    int         last_fall = -1;
    bit         model_next;
    int         wr_cyc[$];
    logic [7:0] wr_dat[$];
    int         wr_fall[$];
    int         done_cyc[$];
    int         err_cyc[$];
    int         viol_wr_busy  = 0;
    int         viol_done_err = 0;
    int         viol_idx      = 0;
    int         done_busy_bad = 0;
    int         err_busy_bad  = 0;

    int n_total = 0;
    int n_pass  = 0;

    // Observe outputs, then update Tx_BUSY, all on the falling edge.
    initial begin
        Tx_BUSY = 1'b0;
        forever begin
            @(negedge clk);
            if (Tx_WR === 1'b1) begin
                wr_cyc.push_back(cyc);
                wr_dat.push_back(Tx_DATA);
                wr_fall.push_back(last_fall);
                if (Tx_BUSY) viol_wr_busy++;
                if (ack_en) remain = busy_len;
            end
            if (done === 1'b1) begin
                done_cyc.push_back(cyc);
                if (busy !== 1'b0) done_busy_bad++;
            end
            if (err === 1'b1) begin
                err_cyc.push_back(cyc);
                if (busy !== 1'b0) err_busy_bad++;
            end
            if (done === 1'b1 && err === 1'b1) viol_done_err++;
            if (byte_idx > 3'(MSG_LEN - 1)) viol_idx++;
            model_next = (cyc < hold_until) || (remain > 0);
            if (remain > 0) remain--;
            if (Tx_BUSY && !model_next) last_fall = cyc;
            Tx_BUSY = model_next;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear_log();
        wr_cyc.delete();
        wr_dat.delete();
        wr_fall.delete();
        done_cyc.delete();
        err_cyc.delete();
        last_fall = -1;
    endtask

    // One full message: optional pre-held Tx_BUSY, optional second start mid-message.
    task automatic run_msg(input logic [31:0] m, input int blen, input bit restart_mid, input int hold);
        int  s;
        int  n;
        bit  restarted;
        clear_log();
        busy_len  = blen;
        ack_en    = 1'b1;
        restarted = 1'b0;
        if (hold > 0) begin
            hold_until = cyc + 1 + hold;
            tick();
        end
        msg_data = m;
        start    = 1'b1;
        s        = cyc;
        tick();
        start = 1'b0;
        n = 0;
        while (done_cyc.size() == 0 && err_cyc.size() == 0 && n < 4000) begin
            if (restart_mid && !restarted && wr_cyc.size() == 2) begin
                msg_data = ~m;
                start    = 1'b1;
                tick();
                start     = 1'b0;
                restarted = 1'b1;
            end else begin
                tick();
            end
            n++;
        end
        tick();
        tick();
        $display("msg %h blen %0d hold %0d restart %0d: writes %0d done %0d err %0d",
                 m, blen, hold, restart_mid, wr_cyc.size(), done_cyc.size(), err_cyc.size());
        chk("done_count", done_cyc.size(), 1);
        chk("err_count", err_cyc.size(), 0);
        chk("wr_count", wr_cyc.size(), MSG_LEN);
        for (int i = 0; i < MSG_LEN && i < wr_cyc.size(); i++) begin
            chk($sformatf("byte%0d", i), wr_dat[i], m[8*i +: 8]);
            // LOAD follows a gap of GAP cycles, which follows the cycle the fall is seen
            if (i > 0) chk($sformatf("gap%0d", i), wr_cyc[i] - wr_fall[i], GAP + 2);
        end
        if (wr_cyc.size() > 0) begin
            if (hold > 0) begin
                chk("held_no_early_wr", wr_fall[0] >= 0 && wr_cyc[0] > wr_fall[0], 1);
                chk("held_wr_lat", wr_cyc[0] - wr_fall[0], 1);
            end else begin
                chk("start_lat", wr_cyc[0] - s, 2);
            end
        end
        if (done_cyc.size() > 0) chk("done_lat", done_cyc[0] - last_fall, GAP + 1);
        chk("busy_after", busy, 0);
        chk("txen_after", Tx_EN, 0);
    endtask

    initial begin
        int         n;
        logic [31:0] m;
        reset    = 1'b1;
        start    = 1'b0;
        msg_data = '0;
`ifdef UART_SCHED_REPEAT_EN
        stop     = 1'b0;
`endif
        repeat (3) tick();
        chk("reset_outputs", {Tx_EN, Tx_WR, Tx_DATA, busy, done, err, byte_idx}, 0);
        reset = 1'b0;
        tick();
        chk("idle_outputs", {Tx_EN, Tx_WR, busy, done, err}, 0);

        // Basic message, transmitter busy 10 cycles per frame
        run_msg(32'h1122_C485, 10, 1'b0, 0);

        // Transmitter occupied for 20 cycles when start arrives
        run_msg(32'hA55A_3C01, 7, 1'b0, 20);

        // Transmitter never acknowledges
        clear_log();
        ack_en   = 1'b0;
        msg_data = 32'hDEAD_BEEF;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (err_cyc.size() == 0 && n < 500) begin
            tick();
            n++;
        end
        tick();
        $display("timeout: writes %0d err %0d done %0d", wr_cyc.size(), err_cyc.size(), done_cyc.size());
        chk("to_err_count", err_cyc.size(), 1);
        chk("to_wr_count", wr_cyc.size(), 1);
        chk("to_done_count", done_cyc.size(), 0);
        if (err_cyc.size() > 0 && wr_cyc.size() > 0) chk("to_err_lat", err_cyc[0] - wr_cyc[0], ACK);
        chk("to_busy_at_err", err_busy_bad, 0);
        chk("to_busy_after", busy, 0);
        chk("to_wr_data", (wr_dat.size() > 0) ? wr_dat[0] : 8'hxx, 8'hEF);
        ack_en = 1'b1;

        // Reset while byte 1 is on the wire
        clear_log();
        busy_len = 30;
        msg_data = 32'h7766_5544;
        start    = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (wr_cyc.size() < 2 && n < 500) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk("mid_byte_idx", byte_idx, 1);
        chk("mid_in_tx", {Tx_BUSY, busy}, 2'b11);
        reset = 1'b1;
        tick();
        $display("reset mid-message: outputs %h", {Tx_EN, Tx_WR, Tx_DATA, busy, done, err, byte_idx});
        chk("mid_reset_outputs", {Tx_EN, Tx_WR, Tx_DATA, busy, done, err, byte_idx}, 0);
        reset = 1'b0;
        n = 0;
        while (Tx_BUSY && n < 100) begin
            tick();
            n++;
        end
        tick();
        chk("mid_no_done_err", done_cyc.size() + err_cyc.size(), 0);
        chk("mid_no_more_wr", wr_cyc.size(), 2);
        run_msg(32'h0BAD_F00D, 6, 1'b0, 0);

        // Second start mid-message is ignored
        run_msg(32'h1357_9BDF, 5, 1'b1, 0);

        // Randomized messages and frame lengths
        for (int k = 0; k < 6; k++) begin
            m = $urandom;
            run_msg(m, int'($urandom_range(1, 25)), 1'($urandom_range(0, 1)), 0);
        end

        chk("never_wr_while_busy", viol_wr_busy, 0);
        chk("never_done_and_err", viol_done_err, 0);
        chk("idx_in_range", viol_idx, 0);
        chk("busy_low_at_done", done_busy_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
